// File: rtl/hilo_unit_pkg.sv
// Shared constants and types for the HI/LO unit: funct encodings, FSM states,
// and the command decode used by the execute stage.
package hilo_unit_pkg;

  localparam logic [5:0] EXE_MULT  = 6'b011000;
  localparam logic [5:0] EXE_MULTU = 6'b011001;
  localparam logic [5:0] EXE_MTHI  = 6'b010001;
  localparam logic [5:0] EXE_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    HILO_IDLE = 2'd0,
    HILO_MUL  = 2'd1,
    HILO_DONE = 2'd2
  } hilo_state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_MUL,
    CMD_MTHI,
    CMD_MTLO
  } hilo_cmd_e;

  function automatic hilo_cmd_e decode_cmd(input logic [5:0] funct);
    case (funct)
      EXE_MULT, EXE_MULTU: decode_cmd = CMD_MUL;
      EXE_MTHI:            decode_cmd = CMD_MTHI;
      EXE_MTLO:            decode_cmd = CMD_MTLO;
      default:             decode_cmd = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hilo_unit_mul_iter.sv
// Unsigned radix-2 shift-add multiplier: one multiplier bit per step, WIDTH steps.
// The multiplier rides in the low half of the accumulator and shifts out as the product shifts in.
module mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum;

  // Top accumulator bit catches the carry of the add before it is shifted down.
  always_comb begin
    sum = acc_q[2*WIDTH:WIDTH];
    if (acc_q[0]) sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      acc_q   <= {{(WIDTH+1){1'b0}}, mplier_in};
      mcand_q <= mcand_in;
      cnt_q   <= '0;
    end else if (step) begin
      acc_q   <= {1'b0, sum, acc_q[WIDTH-1:1]};
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign last    = (cnt_q == CNT_W'(WIDTH-1));
  assign product = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO register pair: MTHI/MTLO writes and an iterative MULT/MULTU
// that stalls the pipeline until the signed-corrected product lands in {HI,LO}.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hilowrite,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall_o
);

  hilo_state_e        state_q, state_n;
  hilo_cmd_e          cmd;
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_q;
  logic               mul_start, mul_step, mul_last;
  logic               hilo_we, mthi_we, mtlo_we;
  logic [2*WIDTH-1:0] product, result;
  logic [WIDTH-1:0]   hi_q, lo_q;

  assign cmd       = (en && hilowrite && !flush) ? decode_cmd(funct) : CMD_NONE;
  assign is_signed = (funct == EXE_MULT);

  // Most-negative operand negates to itself, which reads back as the correct unsigned magnitude.
  assign mag_a = (is_signed && srca[WIDTH-1]) ? -srca : srca;
  assign mag_b = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;

  mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .step      (mul_step),
    .mcand_in  (mag_a),
    .mplier_in (mag_b),
    .last      (mul_last),
    .product   (product)
  );

  assign result = sign_q ? -product : product;

  always_ff @(posedge clk) begin
    if (rst) state_q <= HILO_IDLE;
    else     state_q <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n   = state_q;
    stall_o   = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    hilo_we   = 1'b0;
    mthi_we   = 1'b0;
    mtlo_we   = 1'b0;
    case (state_q)
      HILO_IDLE: begin
        case (cmd)
          CMD_MUL: begin
            mul_start = 1'b1;
            stall_o   = 1'b1;
            state_n   = HILO_MUL;
          end
          CMD_MTHI: mthi_we = 1'b1;
          CMD_MTLO: mtlo_we = 1'b1;
          default: ;
        endcase
      end
      HILO_MUL: begin
        if (flush) begin
          state_n = HILO_IDLE;
        end else begin
          stall_o  = 1'b1;
          mul_step = 1'b1;
          if (mul_last) state_n = HILO_DONE;
        end
      end
      HILO_DONE: begin
        // Stall is released here so the MULT retires on the same edge that writes HI/LO.
        hilo_we = !flush;
        state_n = HILO_IDLE;
      end
      default: state_n = HILO_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)            sign_q <= 1'b0;
    else if (mul_start) sign_q <= is_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      {hi_q, lo_q} <= result;
    end else begin
      if (mthi_we) hi_q <= srca;
      if (mtlo_we) lo_q <= srca;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: MTHI/MTLO, signed/unsigned multiplies with stall
// length checks, flush and reset abandonment, and command gating.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, hilowrite, flush;
  logic [5:0]  funct;
  logic [31:0] srca, srcb;
  logic [31:0] hi_o, lo_o;
  logic        stall_o;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hilowrite (hilowrite),
    .funct     (funct),
    .srca      (srca),
    .srcb      (srcb),
    .flush     (flush),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stall_o   (stall_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; hilowrite = 1'b0; flush = 1'b0; funct = 6'd0;
  endtask

  // Issue a multiply, count stall cycles, then pop the expected product and compare.
  task automatic run_mul(input string tag, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int n;
    logic [63:0] want;
    sb.push_back(exp);
    en = 1'b1; hilowrite = 1'b1; funct = f; srca = a; srcb = b;
    @(negedge clk);
    check({tag, "_stall_start"}, 64'(stall_o), 64'd1);
    n = stall_o ? 1 : 0;
    next_cycle();
    // Garbage operands and a would-be MTLO while busy must be ignored.
    funct = EXE_MTLO; srca = $urandom; srcb = $urandom;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      n++;
    end
    idle_inputs();
    next_cycle();
    check({tag, "_stall_len"}, 64'(n), 64'd33);
    want = sb.pop_front();
    check({tag, "_hi"}, 64'(hi_o), 64'(want[63:32]));
    check({tag, "_lo"}, 64'(lo_o), 64'(want[31:0]));
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    if (sgn) begin
      sa  = $signed({{32{a[31]}}, a});
      sbv = $signed({{32{b[31]}}, b});
      return sa * sbv;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; srca = '0; srcb = '0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    check("reset_hi", 64'(hi_o), 64'd0);
    check("reset_lo", 64'(lo_o), 64'd0);
    check("reset_stall", 64'(stall_o), 64'd0);

    // MTHI then MTLO, never stalling.
    en = 1'b1; hilowrite = 1'b1; funct = EXE_MTHI; srca = 32'h12345678;
    @(negedge clk);
    check("mthi_stall", 64'(stall_o), 64'd0);
    next_cycle();
    funct = EXE_MTLO; srca = 32'h9ABCDEF0;
    check("mthi_hi", 64'(hi_o), 64'h12345678);
    check("mthi_lo_kept", 64'(lo_o), 64'd0);
    @(negedge clk);
    check("mtlo_stall", 64'(stall_o), 64'd0);
    next_cycle();
    idle_inputs();
    check("mtlo_hi_kept", 64'(hi_o), 64'h12345678);
    check("mtlo_lo", 64'(lo_o), 64'h9ABCDEF0);

    run_mul("mult_neg1x2", EXE_MULT, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE);
    run_mul("multu_max", EXE_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_mul("mult_minxmin", EXE_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_mul("mult_minx1", EXE_MULT, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000);

    // Flush in cycle 10 abandons the multiply.
    en = 1'b1; hilowrite = 1'b1; funct = EXE_MULT; srca = 32'd7; srcb = 32'd6;
    next_cycle();
    idle_inputs();
    for (int i = 1; i < 10; i++) next_cycle();
    flush = 1'b1;
    #1;
    check("flush_stall_drop", 64'(stall_o), 64'd0);
    next_cycle();
    flush = 1'b0;
    for (int i = 0; i < 40; i++) next_cycle();
    check("flush_stall_after", 64'(stall_o), 64'd0);
    check("flush_hi_kept", 64'(hi_o), 64'hFFFFFFFF);
    check("flush_lo_kept", 64'(lo_o), 64'h80000000);

    run_mul("mult_7x6", EXE_MULT, 32'd7, 32'd6, 64'h00000000_0000002A);

    ra = $urandom; rb = $urandom;
    run_mul("mult_rand", EXE_MULT, ra, rb, model(1'b1, ra, rb));
    ra = $urandom; rb = $urandom;
    run_mul("multu_rand", EXE_MULTU, ra, rb, model(1'b0, ra, rb));
    run_mul("mult_zero", EXE_MULT, 32'd0, 32'hFFFFFFF9, 64'd0);

    // Reset mid-multiply.
    en = 1'b1; hilowrite = 1'b1; funct = EXE_MULTU; srca = 32'd3; srcb = 32'd5;
    next_cycle();
    idle_inputs();
    for (int i = 1; i < 5; i++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("rst_mid_hi", 64'(hi_o), 64'd0);
    check("rst_mid_lo", 64'(lo_o), 64'd0);
    check("rst_mid_stall", 64'(stall_o), 64'd0);
    for (int i = 0; i < 40; i++) next_cycle();
    check("rst_no_late_lo", 64'(lo_o), 64'd0);

    // No start without hilowrite; no MTHI under flush.
    en = 1'b1; hilowrite = 1'b0; funct = EXE_MULT; srca = 32'd9; srcb = 32'd9;
    @(negedge clk);
    check("nohw_stall", 64'(stall_o), 64'd0);
    next_cycle();
    check("nohw_stall_next", 64'(stall_o), 64'd0);
    hilowrite = 1'b1; funct = EXE_MTHI; flush = 1'b1; srca = 32'hDEADBEEF;
    next_cycle();
    idle_inputs();
    check("flush_mthi_hi", 64'(hi_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage owner of the HI/LO register pair; consumes the main decoder's hilowrite strobe plus funct.
- MTHI/MTLO: single-cycle writes.
- MULT/MULTU: radix-2 shift-add iterative multiply; the hazard unit stalls the pipeline through stall_o until the product is written to HI/LO.
- hi_o/lo_o feed the MFHI/MFLO result mux.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold values 0..WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  valid, non-bubble instruction present in EX
- hilowrite  in  1  decoder strobe; HI/LO-writing instruction
- funct  in  6  instruction funct field
- srca  in  WIDTH  rs operand, forwarded
- srcb  in  WIDTH  rt operand, forwarded
- flush  in  1  exception/redirect flush of EX
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register
- stall_o  out  1  hold IF/ID/EX; multiply in progress

Behaviour:
- Reset (rst=1 at a clk edge):
  - hi_o=0, lo_o=0, state=IDLE, counter=0, accumulator=0.
  - stall_o=0 in the following cycle.
  - Reset mid-multiply abandons the operation; no HI/LO write.
- Commands (all decoded only when en && hilowrite && !flush):
  - start = funct==EXE_MULT or EXE_MULTU.
  - mthi = funct==EXE_MTHI.
  - mtlo = funct==EXE_MTLO.
- MTHI: HI<=srca at the clk edge. MTLO: LO<=srca at the clk edge. Both only in IDLE, never stall; the other register is unchanged.
- FSM states:
  - IDLE:
    - On start, latch into internal registers: multiplicand magnitude, multiplier magnitude, result sign (srca[31]^srcb[31] for MULT; 0 for MULTU). Clear accumulator and counter. Go to MUL.
    - stall_o is combinationally 1 during the start cycle.
  - MUL:
    - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator; shift right one bit; counter++.
    - After WIDTH iterations go to DONE.
    - stall_o=1.
  - DONE:
    - Apply the result sign: two's-complement negate the 2*WIDTH product if the sign is set.
    - Write {HI,LO} at the clk edge ending DONE.
    - stall_o=0, so the MULT retires from EX on that same edge. Go to IDLE.
- Timing:
  - Start cycle is cycle 0; MUL occupies cycles 1..WIDTH; DONE is cycle WIDTH+1.
  - stall_o is high for WIDTH+1 cycles (33 at the default WIDTH).
  - The new HI/LO is visible on hi_o/lo_o from cycle WIDTH+2.
- Signed magnitudes:
  - MULT uses abs(srca) and abs(srcb) as WIDTH-bit unsigned values. 0x80000000 maps to magnitude 0x80000000, which is exact.
  - MULTU uses the operands raw.
  - Accumulator is 2*WIDTH+1 bits to keep the add carry.
- Operand stability:
  - Operands are sampled only in the start cycle.
  - Changes to srca/srcb/funct/en during MUL are ignored.
- Flush:
  - flush=1 in IDLE suppresses start, MTHI and MTLO.
  - flush=1 in MUL or DONE returns to IDLE next cycle with no HI/LO write, and stall_o drops the same cycle.
- hi_o/lo_o are straight register outputs; a same-cycle write is not forwarded. The MFHI-after-MTHI hazard is handled by the hazard unit.
- A zero operand still takes the full WIDTH iterations; there is no early termination.

Decomposition:
- defines.vh gains the FSM state encodings HILO_IDLE, HILO_MUL and HILO_DONE.
- Existing EXE_MULT, EXE_MULTU, EXE_MTHI and EXE_MTLO funct constants are reused.
- One sub-module, mul_iter: an unsigned shift-add datapath with start/done.
  - Contains the accumulator, counter and iteration logic.
  - hilo_unit keeps the FSM, sign handling, HI/LO registers and stall.

Test Plan:
- Reset, then MTHI srca=0x12345678 followed by MTLO srca=0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0, stall_o never asserted.
- MULT srca=0xFFFFFFFF (-1), srcb=0x00000002 -> stall_o high exactly 33 cycles; then hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE.
- MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- MULT srca=0x80000000, srcb=0x80000000 -> hi_o=0x40000000, lo_o=0x00000000. MULT 0x80000000 x 0x00000001 -> hi_o=0xFFFFFFFF, lo_o=0x80000000.
- Start MULT 7x6 and assert flush at cycle 10 -> stall_o falls that cycle; HI/LO keep their prior values. Next MULT 7x6 -> lo_o=0x0000002A, hi_o=0.
- Start MULTU 3x5 and assert rst at cycle 5 -> hi_o=lo_o=0 and stall_o=0 after the edge. en with hilowrite=0 and funct=EXE_MULT -> no start.
